pc_btb_unit: RTL and testbench

Parametrised fetch-PC generator with an integrated direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters.
- Each cycle it produces the instruction-memory address and a taken/target prediction that travels down the pipe with the instruction.
- It accepts branch resolution from EX, trains the BTB and redirects fetch on misprediction.
- It applies the data-memory-fetch (LWI) address override.
- It sits between the stall/hazard logic, the instruction memory and the EX-stage branch unit.

---
 rtl/pc_btb_pkg.sv | 20 ++
 rtl/btb_array.sv | 101 ++++++++++
 rtl/pc_btb_unit.sv | 133 +++++++++++++
 tb/tb_pc_btb_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_btb_pkg.sv
// Shared types and helpers for the fetch-PC / BTB slice.
// Direction counters are 2-bit saturating; bit 1 is the taken prediction.
package pc_btb_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT = 2'd0;
  localparam ctr_t WNT = 2'd1;
  localparam ctr_t WT  = 2'd2;
  localparam ctr_t ST  = 2'd3;

  function automatic ctr_t ctr_inc(input ctr_t c);
    return (c == ST) ? ST : ctr_t'(c + 2'd1);
  endfunction

  function automatic ctr_t ctr_dec(input ctr_t c);
    return (c == SNT) ? SNT : ctr_t'(c - 2'd1);
  endfunction

endpackage

// File: rtl/btb_array.sv
// Direct-mapped BTB storage: combinational lookup port and a synchronous
// training port driven by branch resolution. Only the valid bits are reset;
// tag/target/counter contents are meaningless until their entry is allocated.
// A lookup and a training write to the same index in one cycle sees the old
// contents (no bypass).
module btb_array
  import pc_btb_pkg::*;
#(
  parameter int PC_W     = 16,
  parameter int ENTRIES  = 16,
  parameter int CTR_INIT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] rd_pc,
  output logic            rd_hit,
  output logic            rd_taken,
  output logic [PC_W-1:0] rd_target,
  input  logic            wr_en,
  input  logic [PC_W-1:0] wr_pc,
  input  logic            wr_taken,
  input  logic [PC_W-1:0] wr_target
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
    ctr_t             ctr;
  } entry_t;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [PC_W-1:0]    target_q [ENTRIES];
  ctr_t               ctr_q    [ENTRIES];

  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;
  entry_t           wr_cur;
  entry_t           entry_d;
  logic             wr_hit;
  logic             wr_we;

  assign rd_idx = rd_pc[IDX_W-1:0];
  assign rd_tag = rd_pc[PC_W-1:IDX_W];
  assign wr_idx = wr_pc[IDX_W-1:0];
  assign wr_tag = wr_pc[PC_W-1:IDX_W];

  // Lookup on the registered fetch PC.
  always_comb begin
    rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    rd_taken  = ctr_q[rd_idx][1];
    rd_target = target_q[rd_idx];
  end

  // Training decision: update on tag hit, allocate on taken miss.
  always_comb begin
    wr_cur  = '{valid_q[wr_idx], tag_q[wr_idx], target_q[wr_idx], ctr_q[wr_idx]};
    wr_hit  = wr_cur.valid && (wr_cur.tag == wr_tag);
    wr_we   = 1'b0;
    entry_d = wr_cur;
    if (wr_en) begin
      if (wr_hit) begin
        wr_we = 1'b1;
        if (wr_taken) begin
          entry_d.ctr    = ctr_inc(wr_cur.ctr);
          entry_d.target = wr_target;
        end else begin
          entry_d.ctr    = ctr_dec(wr_cur.ctr);
        end
      end else if (wr_taken) begin
        wr_we   = 1'b1;
        entry_d = '{1'b1, wr_tag, wr_target, ctr_t'(CTR_INIT)};
      end
    end
  end

  // Valid bits carry the only reset in the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wr_we) begin
      valid_q[wr_idx] <= entry_d.valid;
    end
  end

  // Payload storage, written only when training touches the entry.
  always_ff @(posedge clk) begin
    if (wr_we) begin
      tag_q[wr_idx]    <= entry_d.tag;
      target_q[wr_idx] <= entry_d.target;
      ctr_q[wr_idx]    <= entry_d.ctr;
    end
  end

endmodule

// File: rtl/pc_btb_unit.sv
// Fetch-PC generator with direct-mapped BTB prediction, EX-stage redirect on
// misprediction and the LWI address override on the instruction-memory port.
// Optional lookup/hit/mispredict counters are built when PC_BTB_STATS_EN is
// defined.
module pc_btb_unit
  import pc_btb_pkg::*;
#(
  parameter int              PC_W        = 16,
  parameter int              BTB_ENTRIES = 16,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int              CTR_INIT    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            ex_resolve,
  input  logic [PC_W-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [PC_W-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [PC_W-1:0] ex_pred_target,
  input  logic            lwi_sel,
  input  logic [PC_W-1:0] lwi_addr,
  output logic [PC_W-1:0] pc,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  output logic [PC_W-1:0] pc_plus1,
  output logic            mispredict
`ifdef PC_BTB_STATS_EN
  ,
  input  logic            stat_clr,
  output logic [31:0]     stat_lookups,
  output logic [31:0]     stat_hits,
  output logic [31:0]     stat_mispredicts
`endif
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic            btb_hit;
  logic            btb_taken;
  logic [PC_W-1:0] btb_target;

  btb_array #(
    .PC_W     (PC_W),
    .ENTRIES  (BTB_ENTRIES),
    .CTR_INIT (CTR_INIT)
  ) u_btb (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_pc     (pc_q),
    .rd_hit    (btb_hit),
    .rd_taken  (btb_taken),
    .rd_target (btb_target),
    .wr_en     (ex_resolve),
    .wr_pc     (ex_pc),
    .wr_taken  (ex_taken),
    .wr_target (ex_target)
  );

  // Prediction, misprediction and the imem address mux.
  always_comb begin
    pc_plus1    = pc_q + PC_W'(1);
    pred_taken  = btb_hit && btb_taken;
    pred_target = btb_hit ? btb_target : pc_plus1;
    mispredict  = ex_resolve &&
                  ((ex_taken != ex_pred_taken) ||
                   (ex_taken && (ex_pred_target != ex_target)));
    pc          = lwi_sel ? lwi_addr : pc_q;
  end

  // Next PC: redirect beats stall, because it kills the stalled instructions.
  always_comb begin
    pc_d = pc_q;
    if (mispredict) begin
      pc_d = ex_taken ? ex_target : ex_pc + PC_W'(1);
    end else if (!stall) begin
      pc_d = pred_taken ? btb_target : pc_plus1;
    end
  end

  // Fetch PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

`ifdef PC_BTB_STATS_EN
  logic [31:0] stat_lookups_q, stat_lookups_d;
  logic [31:0] stat_hits_q, stat_hits_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  // Saturating event counters with synchronous clear.
  always_comb begin
    stat_lookups_d     = stat_lookups_q;
    stat_hits_d        = stat_hits_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (stat_clr) begin
      stat_lookups_d     = '0;
      stat_hits_d        = '0;
      stat_mispredicts_d = '0;
    end else begin
      if (!stall && (stat_lookups_q != '1))
        stat_lookups_d = stat_lookups_q + 32'd1;
      if (btb_hit && !stall && (stat_hits_q != '1))
        stat_hits_d = stat_hits_q + 32'd1;
      if (mispredict && (stat_mispredicts_q != '1))
        stat_mispredicts_d = stat_mispredicts_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_lookups_q     <= '0;
      stat_hits_q        <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_lookups_q     <= stat_lookups_d;
      stat_hits_q        <= stat_hits_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_lookups     = stat_lookups_q;
  assign stat_hits        = stat_hits_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_pc_btb_unit.sv
// Bench for pc_btb_unit (default parameters): directed scenarios followed by
// random traffic, all checked against a table-level model of the BTB.
module tb_pc_btb_unit;

  localparam int N = 16;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        ex_resolve;
  logic [15:0] ex_pc;
  logic        ex_taken;
  logic [15:0] ex_target;
  logic        ex_pred_taken;
  logic [15:0] ex_pred_target;
  logic        lwi_sel;
  logic [15:0] lwi_addr;
  logic [15:0] pc;
  logic        pred_taken;
  logic [15:0] pred_target;
  logic [15:0] pc_plus1;
  logic        mispredict;
`ifdef PC_BTB_STATS_EN
  logic        stat_clr;
  logic [31:0] stat_lookups;
  logic [31:0] stat_hits;
  logic [31:0] stat_mispredicts;
  int          m_lookups;
  int          m_hits;
  int          m_mps;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: one record per BTB slot plus the fetch PC.
  bit          m_valid [N];
  int          m_tag   [N];
  logic [15:0] m_tgt   [N];
  int          m_ctr   [N];
  logic [15:0] m_pc;

  pc_btb_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .ex_resolve     (ex_resolve),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .lwi_sel        (lwi_sel),
    .lwi_addr       (lwi_addr),
    .pc             (pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .pc_plus1       (pc_plus1),
    .mispredict     (mispredict)
`ifdef PC_BTB_STATS_EN
    ,
    .stat_clr         (stat_clr),
    .stat_lookups     (stat_lookups),
    .stat_hits        (stat_hits),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    m_pc = 16'h0000;
`ifdef PC_BTB_STATS_EN
    m_lookups = 0; m_hits = 0; m_mps = 0;
`endif
  endtask

  task automatic model_lookup(input logic [15:0] a, output bit hit, output bit tk,
                              output logic [15:0] tgt);
    int i;
    i   = int'(a) % N;
    hit = m_valid[i] && (m_tag[i] == int'(a) / N);
    tk  = hit && (m_ctr[i] >= 2);
    tgt = hit ? m_tgt[i] : 16'(a + 16'd1);
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then advance model.
  task automatic step(input bit st, input bit res, input logic [15:0] epc, input bit tk,
                      input logic [15:0] tgt, input bit ptk, input logic [15:0] ptgt,
                      input bit ls, input logic [15:0] la);
    bit          hit, etk, mp, ehit;
    logic [15:0] etgt, dummy;
    int          i;
    stall = st; ex_resolve = res; ex_pc = epc; ex_taken = tk; ex_target = tgt;
    ex_pred_taken = ptk; ex_pred_target = ptgt; lwi_sel = ls; lwi_addr = la;
    #1;
    model_lookup(m_pc, hit, etk, etgt);
    mp = res && ((tk != ptk) || (tk && ptgt != tgt));
    chk("pc", 32'(pc), 32'(ls ? la : m_pc));
    chk("pred_taken", 32'(pred_taken), 32'(etk));
    chk("pred_target", 32'(pred_target), 32'(etgt));
    chk("pc_plus1", 32'(pc_plus1), 32'(16'(m_pc + 16'd1)));
    chk("mispredict", 32'(mispredict), 32'(mp));
    @(posedge clk);
`ifdef PC_BTB_STATS_EN
    if (!st) m_lookups++;
    if (hit && !st) m_hits++;
    if (mp) m_mps++;
`endif
    if (mp) m_pc = tk ? tgt : 16'(epc + 16'd1);
    else if (!st) m_pc = etk ? etgt : 16'(m_pc + 16'd1);
    if (res) begin
      model_lookup(epc, ehit, etk, dummy);
      i = int'(epc) % N;
      if (ehit) begin
        if (tk) begin
          m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
          m_tgt[i] = tgt;
        end else begin
          m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (tk) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = int'(epc) / N;
        m_tgt[i]   = tgt;
        m_ctr[i]   = 2;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit          h, ptk, res, tk;
    logic [15:0] ptgt, epc, tgt;
    rst_n = 1'b0; stall = 0; ex_resolve = 0; ex_pc = 0; ex_taken = 0; ex_target = 0;
    ex_pred_taken = 0; ex_pred_target = 0; lwi_sel = 0; lwi_addr = 0;
`ifdef PC_BTB_STATS_EN
    stat_clr = 0;
`endif
    model_reset();
    @(negedge clk);
    #1;
    chk("reset_pc", 32'(pc), 32'h0);
    chk("reset_pred", 32'(pred_taken), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential fetch from reset.
    idle(4);
    // Train a taken branch at 5, then revisit it.
    step(0, 1, 16'h0005, 1, 16'h0020, 0, 16'h0000, 0, 0);
    step(0, 1, 16'h0030, 1, 16'h0005, 0, 16'h0000, 0, 0);
    idle(2);
    // Two not-taken resolves walk the counter down.
    step(0, 1, 16'h0005, 0, 16'h0000, 1, 16'h0020, 0, 0);
    step(0, 1, 16'h0005, 0, 16'h0000, 0, 16'h0000, 0, 0);
    step(0, 1, 16'h0040, 1, 16'h0005, 0, 16'h0000, 0, 0);
    idle(1);
    // Aliasing allocation evicts the old entry at index 5.
    step(0, 1, 16'h0015, 1, 16'h0040, 0, 16'h0000, 0, 0);
    step(0, 1, 16'h0050, 1, 16'h0005, 0, 16'h0000, 0, 0);
    idle(1);
    step(0, 1, 16'h0060, 1, 16'h0015, 0, 16'h0000, 0, 0);
    idle(1);
    // Redirect under stall, then plain stall.
    step(1, 1, 16'h0070, 1, 16'h0030, 0, 16'h0000, 0, 0);
    for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // LWI override for one cycle.
    step(0, 0, 0, 0, 0, 0, 0, 1, 16'h0100);
    idle(1);
    // Wrap-around of pc_plus1 and ex_pc+1.
    step(0, 1, 16'h0070, 1, 16'hFFFF, 1, 16'h0030, 0, 0);
    idle(1);
    step(0, 1, 16'hFFFF, 0, 16'h0000, 1, 16'h1234, 0, 0);
    idle(1);

    // Asynchronous reset mid-run.
    rst_n = 1'b0;
    #1;
    chk("midrst_pc", 32'(pc), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // Random traffic over a small address window so entries alias and retrain.
    for (int n = 0; n < 600; n++) begin
      res = ($urandom_range(0, 9) < 4);
      epc = 16'($urandom_range(0, 63));
      tk  = $urandom_range(0, 1) == 1;
      tgt = ($urandom_range(0, 31) == 0) ? 16'hFFFF : 16'($urandom_range(0, 63));
      if ($urandom_range(0, 9) < 7) model_lookup(epc, h, ptk, ptgt);
      else begin
        ptk  = $urandom_range(0, 1) == 1;
        ptgt = 16'($urandom_range(0, 63));
      end
      step($urandom_range(0, 3) == 0, res, epc, tk, tgt, ptk, ptgt,
           $urandom_range(0, 9) == 0, 16'($urandom));
    end

`ifdef PC_BTB_STATS_EN
    chk("stat_lookups", stat_lookups, 32'(m_lookups));
    chk("stat_hits", stat_hits, 32'(m_hits));
    chk("stat_mispredicts", stat_mispredicts, 32'(m_mps));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
